// File: rtl/warp_hart_core.sv
// Minimal in-order RV64 OP-IMM hart: packet fetch, dual decode/issue, single-cycle execute,
// write back into a 32x64 register file. Forwarding from execute and write-back hides result latency.
module warp_hart_xrf (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_we,
    input  logic [4:0]  i_wa0,
    input  logic [4:0]  i_wa1,
    input  logic [63:0] i_wd0,
    input  logic [63:0] i_wd1,
    input  logic [4:0]  i_ra0,
    input  logic [4:0]  i_ra1,
    output logic [63:0] o_rd0,
    output logic [63:0] o_rd1
);
    logic [63:0] file [0:31];

    // Port 1 carries the younger slot, so its write lands last and wins on equal rd.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) file[i] <= '0;
        end else begin
            if (i_we[0] && (i_wa0 != 5'd0)) file[i_wa0] <= i_wd0;
            if (i_we[1] && (i_wa1 != 5'd0)) file[i_wa1] <= i_wd1;
        end
    end

    assign o_rd0 = (i_ra0 == 5'd0) ? 64'd0 : file[i_ra0];
    assign o_rd1 = (i_ra1 == 5'd0) ? 64'd0 : file[i_ra1];
endmodule

module warp_hart_core #(
    parameter logic [38:0] RESET_ADDR = 39'h4000000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_ren,
    output logic [38:0] o_imem_raddr,
    input  logic        i_imem_valid,
    input  logic [63:0] i_imem_rdata
);
    typedef struct packed {
        logic        ok;
        logic        unit_b;
        logic        we;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [2:0]  f3;
        logic        alt;
        logic        isw;
        logic [63:0] imm;
    } dec_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        alt;
        logic        isw;
        logic [63:0] imm;
    } ex_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d        = '0;
        d.rd     = ins[11:7];
        d.rs1    = ins[19:15];
        d.f3     = ins[14:12];
        d.alt    = ins[30];
        d.imm    = {{52{ins[31]}}, ins[31:20]};
        if (ins[6:0] == 7'b0010011) begin
            case (ins[14:12])
                3'd1:    d.ok = (ins[31:26] == 6'd0);
                3'd5:    d.ok = (ins[31:26] == 6'd0) || (ins[31:26] == 6'b010000);
                default: d.ok = 1'b1;
            endcase
            d.unit_b = (ins[14:12] == 3'd4) || (ins[14:12] == 3'd6) || (ins[14:12] == 3'd7);
        end else if (ins[6:0] == 7'b0011011) begin
            d.isw = 1'b1;
            case (ins[14:12])
                3'd0:    d.ok = 1'b1;
                3'd1:    d.ok = (ins[31:25] == 7'd0);
                3'd5:    d.ok = (ins[31:25] == 7'd0) || (ins[31:25] == 7'b0100000);
                default: d.ok = 1'b0;
            endcase
        end
        d.we = d.ok && (d.rd != 5'd0);
        return d;
    endfunction

    // NOPs occupy no unit, so they never block pairing.
    function automatic logic dual_ok(input dec_t d0, input dec_t d1);
        logic unit_clash;
        logic raw;
        unit_clash = d0.ok && d1.ok && (d0.unit_b == d1.unit_b);
        raw        = d0.we && d1.ok && (d1.rs1 == d0.rd);
        return !unit_clash && !raw;
    endfunction

    function automatic ex_t to_ex(input dec_t d);
        ex_t e;
        e.we  = d.we;
        e.rd  = d.rd;
        e.f3  = d.f3;
        e.alt = d.alt;
        e.isw = d.isw;
        e.imm = d.imm;
        return e;
    endfunction

    function automatic logic [63:0] alu(input ex_t e, input logic [63:0] a);
        logic signed [63:0] sa;
        logic signed [63:0] si;
        logic signed [31:0] sw;
        logic        [31:0] w;
        logic        [63:0] r;
        sa = a;
        si = e.imm;
        sw = a[31:0];
        w  = '0;
        r  = '0;
        if (e.isw) begin
            case (e.f3)
                3'd1: w = a[31:0] << e.imm[4:0];
                3'd5: begin
                    if (e.alt) w = sw >>> e.imm[4:0];
                    else       w = a[31:0] >> e.imm[4:0];
                end
                default: w = a[31:0] + e.imm[31:0];
            endcase
            r = {{32{w[31]}}, w};
        end else begin
            case (e.f3)
                3'd0: r = a + e.imm;
                3'd1: r = a << e.imm[5:0];
                3'd2: r = {63'd0, sa < si};
                3'd3: r = {63'd0, a < e.imm};
                3'd4: r = a ^ e.imm;
                3'd5: begin
                    if (e.alt) r = sa >>> e.imm[5:0];
                    else       r = a >> e.imm[5:0];
                end
                3'd6: r = a | e.imm;
                default: r = a & e.imm;
            endcase
        end
        return r;
    endfunction

    logic [38:0] r_pc;
    logic        r_ren;
    logic [63:0] r_dec_p0;
    logic        r_vld_p0;
    logic        r_half_p0;
    ex_t         r_ex_p1  [0:1];
    logic [63:0] r_opa_p1 [0:1];
    logic [1:0]  r_vld_p1;
    logic [1:0]  r_we_p2;
    logic [4:0]  r_rd_p2  [0:1];
    logic [63:0] r_res_p2 [0:1];

    dec_t        w_d0;
    dec_t        w_d1;
    logic        w_dual;
    logic        w_iss0;
    logic        w_iss1;
    logic        w_accept;
    logic        w_in_dual;
    logic [4:0]  w_rs     [0:1];
    logic [63:0] w_rf_rd  [0:1];
    logic [63:0] w_opa    [0:1];
    logic [63:0] w_res_p1 [0:1];

    assign o_imem_ren   = r_ren;
    assign o_imem_raddr = r_pc;

    // Decode / issue: slot 1 goes alone in lane 1 after a serialized slot 0.
    assign w_d0     = decode(r_dec_p0[31:0]);
    assign w_d1     = decode(r_dec_p0[63:32]);
    assign w_dual   = dual_ok(w_d0, w_d1);
    assign w_iss0   = r_vld_p0 && !r_half_p0;
    assign w_iss1   = r_vld_p0 && (r_half_p0 || w_dual);
    assign w_accept = r_ren && i_imem_valid;
    // A pairable packet drains in one cycle, so the next request can go out immediately.
    assign w_in_dual = dual_ok(decode(i_imem_rdata[31:0]), decode(i_imem_rdata[63:32]));
    assign w_rs[0]  = w_d0.rs1;
    assign w_rs[1]  = w_d1.rs1;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_opa[i] = w_rf_rd[i];
            if (r_we_p2[0] && (r_rd_p2[0] == w_rs[i])) w_opa[i] = r_res_p2[0];
            if (r_we_p2[1] && (r_rd_p2[1] == w_rs[i])) w_opa[i] = r_res_p2[1];
            if (r_vld_p1[0] && r_ex_p1[0].we && (r_ex_p1[0].rd == w_rs[i])) w_opa[i] = w_res_p1[0];
            if (r_vld_p1[1] && r_ex_p1[1].we && (r_ex_p1[1].rd == w_rs[i])) w_opa[i] = w_res_p1[1];
        end
    end

    // Execute
    assign w_res_p1[0] = alu(r_ex_p1[0], r_opa_p1[0]);
    assign w_res_p1[1] = alu(r_ex_p1[1], r_opa_p1[1]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc      <= RESET_ADDR;
            r_ren     <= 1'b0;
            r_vld_p0  <= 1'b0;
            r_half_p0 <= 1'b0;
            r_vld_p1  <= '0;
            r_we_p2   <= '0;
        end else begin
            r_ren <= w_accept ? w_in_dual : 1'b1;
            if (w_accept) begin
                r_pc      <= r_pc + 39'd8;
                r_vld_p0  <= 1'b1;
                r_half_p0 <= 1'b0;
            end else if (w_iss1) begin
                r_vld_p0  <= 1'b0;
                r_half_p0 <= 1'b0;
            end else if (w_iss0) begin
                r_half_p0 <= 1'b1;
            end
            r_vld_p1   <= {w_iss1, w_iss0};
            r_we_p2[0] <= r_vld_p1[0] && r_ex_p1[0].we;
            r_we_p2[1] <= r_vld_p1[1] && r_ex_p1[1].we;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) r_dec_p0 <= i_imem_rdata;
        r_ex_p1[0]  <= to_ex(w_d0);
        r_ex_p1[1]  <= to_ex(w_d1);
        r_opa_p1[0] <= w_opa[0];
        r_opa_p1[1] <= w_opa[1];
        // Write back
        for (int i = 0; i < 2; i++) begin
            r_rd_p2[i]  <= r_ex_p1[i].rd;
            r_res_p2[i] <= w_res_p1[i];
        end
    end

    warp_hart_xrf xrf (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_we  (r_we_p2),
        .i_wa0 (r_rd_p2[0]),
        .i_wa1 (r_rd_p2[1]),
        .i_wd0 (r_res_p2[0]),
        .i_wd1 (r_res_p2[1]),
        .i_ra0 (w_rs[0]),
        .i_ra1 (w_rs[1]),
        .o_rd0 (w_rf_rd[0]),
        .o_rd1 (w_rf_rd[1])
    );
endmodule

// File: tb/tb_warp_hart_core.sv
// Scoreboard bench for warp_hart_core: a sequential ISA model queues expected register writes
// per driven packet; queued results and the whole register file are compared after the pipe drains.
module tb_warp_hart_core;
    localparam logic [38:0] RST_A = 39'h4000000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ren;
    logic [38:0] raddr;
    logic        valid = 1'b0;
    logic [63:0] rdata = 64'd0;

    always #5 clk = ~clk;

    warp_hart_core #(.RESET_ADDR(RST_A)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_imem_ren   (ren),
        .o_imem_raddr (raddr),
        .i_imem_valid (valid),
        .i_imem_rdata (rdata)
    );

    typedef struct {
        int          idx;
        logic [63:0] val;
    } exp_t;

    exp_t        sb_q [$];
    logic [63:0] m_rf [0:31];
    logic [38:0] exp_pc;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ienc(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    // Sequential reference: executes one instruction in program order and queues its write.
    function automatic void model(input logic [31:0] ins);
        logic [63:0] a, imm, r;
        logic [31:0] w;
        logic        ok;
        logic [4:0]  rd;
        rd  = ins[11:7];
        a   = m_rf[ins[19:15]];
        imm = {{52{ins[31]}}, ins[31:20]};
        ok  = 1'b1;
        r   = 64'd0;
        w   = 32'd0;
        if (ins[6:0] == 7'h13) begin
            case (ins[14:12])
                3'd0: r = a + imm;
                3'd2: r = ($signed(a) < $signed(imm)) ? 64'd1 : 64'd0;
                3'd3: r = (a < imm) ? 64'd1 : 64'd0;
                3'd4: r = a ^ imm;
                3'd6: r = a | imm;
                3'd7: r = a & imm;
                3'd1: if (ins[31:26] == 6'h00) r = a << ins[25:20]; else ok = 1'b0;
                default: begin
                    if (ins[31:26] == 6'h00)      r = a >> ins[25:20];
                    else if (ins[31:26] == 6'h10) r = $signed(a) >>> ins[25:20];
                    else                          ok = 1'b0;
                end
            endcase
        end else if (ins[6:0] == 7'h1B) begin
            case (ins[14:12])
                3'd0: w = a[31:0] + imm[31:0];
                3'd1: if (ins[31:25] == 7'h00) w = a[31:0] << ins[24:20]; else ok = 1'b0;
                3'd5: begin
                    if (ins[31:25] == 7'h00)      w = a[31:0] >> ins[24:20];
                    else if (ins[31:25] == 7'h20) w = $signed(a[31:0]) >>> ins[24:20];
                    else                          ok = 1'b0;
                end
                default: ok = 1'b0;
            endcase
            r = {{32{w[31]}}, w};
        end else begin
            ok = 1'b0;
        end
        if (ok && (rd != 5'd0)) begin
            m_rf[rd] = r;
            sb_q.push_back('{int'(rd), r});
        end
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [4:0]  rd, rs;
        logic [11:0] imm;
        logic [5:0]  sh;
        logic [31:0] ins;
        rd  = 5'($urandom_range(0, 7));
        rs  = 5'($urandom_range(0, 7));
        imm = 12'($urandom);
        sh  = 6'($urandom);
        case ($urandom_range(0, 13))
            0:  ins = ienc(7'h13, 3'd0, rd, rs, imm);
            1:  ins = ienc(7'h13, 3'd2, rd, rs, imm);
            2:  ins = ienc(7'h13, 3'd3, rd, rs, imm);
            3:  ins = ienc(7'h13, 3'd4, rd, rs, imm);
            4:  ins = ienc(7'h13, 3'd6, rd, rs, imm);
            5:  ins = ienc(7'h13, 3'd7, rd, rs, imm);
            6:  ins = ienc(7'h13, 3'd1, rd, rs, {6'h00, sh});
            7:  ins = ienc(7'h13, 3'd5, rd, rs, {6'h00, sh});
            8:  ins = ienc(7'h13, 3'd5, rd, rs, {6'h10, sh});
            9:  ins = ienc(7'h1B, 3'd0, rd, rs, imm);
            10: ins = ienc(7'h1B, 3'd1, rd, rs, {7'h00, sh[4:0]});
            11: ins = ienc(7'h1B, 3'd5, rd, rs, {7'h00, sh[4:0]});
            12: ins = ienc(7'h1B, 3'd5, rd, rs, {7'h20, sh[4:0]});
            default: ins = $urandom;
        endcase
        return ins;
    endfunction

    task automatic send(input logic [63:0] pkt);
        int n = 0;
        while (ren !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ren !== 1'b1) begin
            check("ren_timeout", {63'd0, ren}, 64'd1);
            return;
        end
        check("raddr", {25'd0, raddr}, {25'd0, exp_pc});
        valid = 1'b1;
        rdata = pkt;
        @(posedge clk);
        #1;
        valid = 1'b0;
        rdata = {$urandom, $urandom};
        model(pkt[31:0]);
        model(pkt[63:32]);
        exp_pc = exp_pc + 39'd8;
    endtask

    task automatic drain();
        exp_t e;
        bit   sup;
        repeat (6) @(negedge clk);
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            sup = 1'b0;
            foreach (sb_q[j]) if (sb_q[j].idx == e.idx) sup = 1'b1;
            if (!sup) check($sformatf("x%0d", e.idx), dut.xrf.file[e.idx], e.val);
        end
        for (int i = 0; i < 32; i++) check($sformatf("rf%0d", i), dut.xrf.file[i], m_rf[i]);
    endtask

    initial begin
        logic [38:0] hold_addr;
        for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
        exp_pc = RST_A;

        #1 rst = 1'b1;
        #1;
        check("rst_ren", {63'd0, ren}, 64'd0);
        check("rst_raddr", {25'd0, raddr}, {25'd0, RST_A});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_ren", {63'd0, ren}, 64'd1);
        check("first_raddr", {25'd0, raddr}, {25'd0, RST_A});

        send({32'h08206113, 32'h07800093});
        check("next_raddr", {25'd0, raddr}, {25'd0, RST_A + 39'd8});
        drain();
        check("tp_x1", dut.xrf.file[1], 64'h78);
        check("tp_x2", dut.xrf.file[2], 64'h82);

        send({ienc(7'h13, 3'd7, 5'd2, 5'd0, 12'h000), ienc(7'h13, 3'd7, 5'd1, 5'd0, 12'h000)});
        send({ienc(7'h13, 3'd0, 5'd2, 5'd0, 12'h082), ienc(7'h13, 3'd0, 5'd1, 5'd0, 12'h078)});
        drain();
        check("ser_x1", dut.xrf.file[1], 64'h78);
        check("ser_x2", dut.xrf.file[2], 64'h82);

        send({ienc(7'h13, 3'd0, 5'd2, 5'd1, 12'h001), ienc(7'h13, 3'd0, 5'd1, 5'd0, 12'h005)});
        drain();
        check("dep_x1", dut.xrf.file[1], 64'd5);
        check("dep_x2", dut.xrf.file[2], 64'd6);

        send({ienc(7'h13, 3'd5, 5'd4, 5'd3, {6'h10, 6'd4}), ienc(7'h13, 3'd0, 5'd3, 5'd0, 12'hFFF)});
        send({ienc(7'h1B, 3'd1, 5'd5, 5'd5, {7'h00, 5'd21}), ienc(7'h1B, 3'd0, 5'd5, 5'd0, 12'h7FF)});
        drain();
        check("sgn_x3", dut.xrf.file[3], 64'hFFFFFFFFFFFFFFFF);
        check("sgn_x4", dut.xrf.file[4], 64'hFFFFFFFFFFFFFFFF);
        check("w_x5", dut.xrf.file[5], 64'hFFFFFFFFFFE00000);

        send({32'h00000000, ienc(7'h13, 3'd0, 5'd0, 5'd0, 12'h005)});
        send({32'h00000033, 32'hFFFFFFFF});
        drain();
        check("x0_zero", dut.xrf.file[0], 64'd0);

        for (int k = 0; k < 40; k++) send({rand_ins(), rand_ins()});
        drain();

        @(negedge clk);
        hold_addr = raddr;
        check("hold_ren0", {63'd0, ren}, 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_ren", {63'd0, ren}, 64'd1);
            check("hold_raddr", {25'd0, raddr}, {25'd0, hold_addr});
        end

        send({rand_ins(), rand_ins()});
        send({ienc(7'h13, 3'd0, 5'd6, 5'd0, 12'h123), ienc(7'h13, 3'd6, 5'd7, 5'd0, 12'h456)});
        #3 rst = 1'b1;
        #1;
        check("mid_rst_ren", {63'd0, ren}, 64'd0);
        check("mid_rst_raddr", {25'd0, raddr}, {25'd0, RST_A});
        for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
        sb_q.delete();
        exp_pc = RST_A;
        for (int i = 0; i < 32; i++) check($sformatf("rst_rf%0d", i), dut.xrf.file[i], 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain();
        check("restart_ren", {63'd0, ren}, 64'd1);
        check("restart_raddr", {25'd0, raddr}, {25'd0, RST_A});
        send({ienc(7'h13, 3'd4, 5'd9, 5'd0, 12'h0F0), ienc(7'h13, 3'd2, 5'd8, 5'd0, 12'h001)});
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/warp_hart_core.md
Name: warp_hart_core

Overview:
- Minimal in-order RV64 hart core: fetches 64-bit instruction packets (two 32-bit instructions) from an instruction memory port.
- Pipeline stages: decode, issue, execute, write back to a 32x64 integer register file.
- Supports the RV64I OP-IMM class. Top-level compute block of the warp design; no data memory port in this revision.

Parameters:
- RESET_ADDR, 39'h4000000000, fetch address after reset; must be 8-byte aligned.

Ports:
- i_clk  input  1  core clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- o_imem_ren  output  1  instruction fetch request.
- o_imem_raddr  output  39  fetch address, always 8-byte aligned.
- i_imem_valid  input  1  i_imem_rdata holds the packet for the outstanding request this cycle.
- i_imem_rdata  input  64  packet; bits [31:0] slot 0 (older, lower address), bits [63:32] slot 1.

Behaviour:
- Reset (asserted, asynchronous):
  - pc = RESET_ADDR.
  - o_imem_ren = 0.
  - o_imem_raddr = RESET_ADDR.
  - All pipeline valid bits cleared.
  - Register file x1..x31 = 0.
  - Reset mid-operation discards all in-flight instructions; there are no partial writes after reset asserts.
- Fetch:
  - First rising edge after reset release sets o_imem_ren = 1, o_imem_raddr = pc.
  - o_imem_ren and o_imem_raddr are held stable until a rising edge samples i_imem_valid = 1.
  - On that edge: packet latched into decode register; pc += 8; request continues with the new address if the decode register can accept, else o_imem_ren = 0 until space frees.
  - i_imem_rdata is ignored when i_imem_valid = 0.
  - One request outstanding at a time.
  - pc wraps modulo 2^39.
- Decode:
  - Both slots decoded in parallel: opcode, rd, rs1, funct3, funct6/7, sign-extended 12-bit immediate.
  - Supported, opcode 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI (6-bit shamt).
  - Supported, opcode 0011011: ADDIW, SLLIW, SRLIW, SRAIW (32-bit result, sign-extended to 64).
  - All other encodings, including all-zero words, retire as NOP with no register write.
- Issue:
  - Two execution units:
    - unit A: add, compare, shift.
    - unit B: AND/OR/XOR only.
  - Both slots issue in the same cycle only if they need different units and slot 1 rs1 != slot 0 rd (or slot 0 rd = x0).
  - Otherwise slot 0 issues first and slot 1 issues the next cycle; fetch/decode stall meanwhile.
  - Operands are read from the register file at issue; x0 reads 0.
- Execute: one cycle; 64-bit two's-complement arithmetic; SLTI/SLTIU produce 0/1.
- Write back:
  - Register file written on the rising edge ending the write-back stage.
  - Writes to x0 are dropped.
  - If both slots write the same rd in one cycle, slot 1 wins.
- Latency:
  - Packet sampled at edge N (i_imem_valid = 1).
  - Dual-issued results are visible in the register file after edge N+3.
  - The register file must be readable by the end of the cycle following N+3.
- Verification hook: register file is instance xrf with storage array file[0:31][63:0], readable by hierarchical reference.

Test Plan:
- Reset, then one packet {32'h08206113, 32'h07800093} (slot 0 ADDI x1,x0,0x78; slot 1 ORI x2,x0,0x82), then valid low -> within 4 edges x1 = 64'h78, x2 = 64'h82, other registers 0. First o_imem_raddr = 39'h4000000000, next = 39'h4000000008.
- Packet {ADDI x2,x0,0x82, ADDI x1,x0,0x78}: both slots need unit A -> serialized, slot 1 one cycle later; final x1 = 0x78, x2 = 0x82.
- Dependent pair {ADDI x2,x1,1 ; ADDI x1,x0,5} -> x1 = 5, x2 = 6.
- Sign and width checks:
  - ADDI x3,x0,-1 -> x3 = 64'hFFFFFFFFFFFFFFFF.
  - SRAI x4,x3,4 -> x4 = all ones.
  - ADDIW x5,x0,0x7FF then SLLIW x5,x5,21 -> x5 = 64'hFFFFFFFFFFE00000.
- Write to x0 (ADDI x0,x0,5), unknown opcode, and zero word -> x0 stays 0; no other register changes.
- Fetch hold and reset:
  - i_imem_valid held low for 10 cycles -> o_imem_ren and o_imem_raddr stay stable.
  - Asserting i_rst mid-pipeline -> registers cleared, o_imem_ren = 0 immediately, fetch restarts at RESET_ADDR.
